spi_host_arbiter: RTL and testbench

//  Host-side scheduler that shares one spi_master between NREQ requesters (register-access clients on host_clk).

---
 rtl/spi_host_arbiter_pkg.sv | 23 ++
 rtl/spi_host_arbiter_rr_arb.sv | 41 ++++
 rtl/spi_host_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_spi_host_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_host_arbiter_pkg.sv
// Shared constants, state encoding and frame-width helper for the SPI host arbiter.
// Frame layout is {cmd, addr, 1'b0, data}, MSB first.
package spi_host_arbiter_pkg;

   localparam logic [1:0] CMD_WR = 2'b10;
   localparam logic [1:0] CMD_RD = 2'b01;

   localparam int DEF_CW = 2;
   localparam int DEF_AW = 19;
   localparam int DEF_DW = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARB  = 2'd1,
      ST_SEND = 2'd2,
      ST_GAP  = 2'd3
   } arb_state_e;

   function automatic int frame_width(input int cw, input int aw, input int dw);
      return cw + aw + 1 + dw;
   endfunction

endpackage

// File: rtl/spi_host_arbiter_rr_arb.sv
// Combinational round-robin picker: first asserted request at or after the pointer,
// wrapping modulo NREQ; returns a one-hot grant, its index and a valid flag.
module spi_host_arbiter_rr_arb #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         req_i,
   input  logic [$clog2(NREQ)-1:0] ptr_i,
   output logic [NREQ-1:0]         gnt_oh_o,
   output logic [$clog2(NREQ)-1:0] gnt_idx_o,
   output logic                    gnt_vld_o
);

   localparam int IW = $clog2(NREQ);

   logic [IW:0]   sum_s;
   logic [IW-1:0] cand_s;
   logic          hit_s;

   // Scan candidates in priority order from the pointer; the first hit sticks.
   always_comb begin
      gnt_oh_o  = '0;
      gnt_idx_o = '0;
      gnt_vld_o = 1'b0;
      sum_s     = '0;
      cand_s    = '0;
      hit_s     = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         sum_s = {1'b0, ptr_i} + (IW+1)'(i);
         if (sum_s >= (IW+1)'(NREQ)) begin
            cand_s = IW'(sum_s - (IW+1)'(NREQ));
         end else begin
            cand_s = sum_s[IW-1:0];
         end
         hit_s            = !gnt_vld_o && req_i[cand_s];
         gnt_oh_o[cand_s] = gnt_oh_o[cand_s] | hit_s;
         gnt_idx_o        = hit_s ? cand_s : gnt_idx_o;
         gnt_vld_o        = gnt_vld_o | hit_s;
      end
   end

endmodule

// File: rtl/spi_host_arbiter.sv
// Round-robin scheduler sharing one spi_master between NREQ register-access requesters.
// Optional watchdog on the SEND state is enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_host_arbiter
   import spi_host_arbiter_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int CW      = DEF_CW,
   parameter int AW      = DEF_AW,
   parameter int DW      = DEF_DW,
   parameter int SW      = 38,
   parameter int GAP     = 8,
   parameter int TIMEOUT = 1024
) (
   input  logic                 host_clk,
   input  logic                 host_rst_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ-1:0]      req_wr,
   input  logic [NREQ*AW-1:0]   req_addr,
   input  logic [NREQ*DW-1:0]   req_wdata,
   output logic [NREQ-1:0]      req_done,
   output logic                 req_err,
   output logic                 busy,
   output logic [SW-1:0]        tx_mosi_data,
   output logic                 tx_mosi_enable,
   input  logic                 tx_mosi_done
);

   localparam int IW = $clog2(NREQ);
   localparam int GW = $clog2(GAP + 1);

   generate
      if ((SW != frame_width(CW, AW, DW)) || (GAP < 1) || (TIMEOUT < 2) || (NREQ < 2) || (NREQ > 8)) begin : g_bad_cfg
         $error("spi_host_arbiter: inconsistent parameters");
      end
   endgenerate

   arb_state_e      state_q;
   logic [IW-1:0]   ptr_q;
   logic [NREQ-1:0] gnt_q;
   logic [NREQ-1:0] req_ready_q;
   logic [NREQ-1:0] req_done_q;
   logic            busy_q;
   logic [SW-1:0]   data_q;
   logic            en_q;
   logic [GW-1:0]   gap_cnt_q;

   logic [NREQ-1:0] gnt_oh_s;
   logic [IW-1:0]   gnt_idx_s;
   logic            gnt_vld_s;
   logic [IW-1:0]   ptr_d;
   logic [AW-1:0]   addr_sel_s;
   logic [DW-1:0]   wdata_sel_s;
   logic [SW-1:0]   frame_d;

   spi_host_arbiter_rr_arb #(.NREQ(NREQ)) u_rr_arb (
      .req_i     (req_valid),
      .ptr_i     (ptr_q),
      .gnt_oh_o  (gnt_oh_s),
      .gnt_idx_o (gnt_idx_s),
      .gnt_vld_o (gnt_vld_s)
   );

   // Candidate frame for the current pick; read data field is forced to zero.
   always_comb begin
      addr_sel_s  = req_addr[int'(gnt_idx_s)*AW +: AW];
      wdata_sel_s = req_wdata[int'(gnt_idx_s)*DW +: DW];
      if (req_wr[gnt_idx_s]) begin
         frame_d = {CW'(CMD_WR), addr_sel_s, 1'b0, wdata_sel_s};
      end else begin
         frame_d = {CW'(CMD_RD), addr_sel_s, 1'b0, {DW{1'b0}}};
      end
      if (gnt_idx_s == IW'(NREQ - 1)) begin
         ptr_d = '0;
      end else begin
         ptr_d = gnt_idx_s + IW'(1);
      end
   end

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int TW_RAW = $clog2(TIMEOUT + 1);
   localparam int TW     = (TW_RAW > 11) ? TW_RAW : 11;
   logic [TW-1:0] tmo_cnt_q;
   logic          req_err_q;
`endif

   // Main FSM with registered handshake, frame and status outputs.
   always_ff @(posedge host_clk) begin
      if (!host_rst_n) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         gnt_q       <= '0;
         req_ready_q <= '0;
         req_done_q  <= '0;
         busy_q      <= 1'b0;
         data_q      <= '0;
         en_q        <= 1'b0;
         gap_cnt_q   <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
         tmo_cnt_q   <= '0;
         req_err_q   <= 1'b0;
`endif
      end else begin
         req_ready_q <= '0;
         req_done_q  <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
         req_err_q   <= 1'b0;
`endif
         case (state_q)
            ST_IDLE: begin
               en_q <= 1'b0;
               if (|req_valid) begin
                  state_q <= ST_ARB;
                  busy_q  <= 1'b1;
               end else begin
                  busy_q  <= 1'b0;
               end
            end
            ST_ARB: begin
               en_q <= 1'b0;
               if (gnt_vld_s) begin
                  req_ready_q <= gnt_oh_s;
                  gnt_q       <= gnt_oh_s;
                  data_q      <= frame_d;
                  ptr_q       <= ptr_d;
                  state_q     <= ST_SEND;
`ifdef SPI_ARB_TIMEOUT_EN
                  tmo_cnt_q   <= '0;
`endif
               end else begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            ST_SEND: begin
               // Done only counts once the frame request is actually visible to the master.
               if (tx_mosi_done && en_q) begin
                  en_q       <= 1'b0;
                  req_done_q <= gnt_q;
                  gap_cnt_q  <= '0;
                  state_q    <= ST_GAP;
`ifdef SPI_ARB_TIMEOUT_EN
               end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                  en_q       <= 1'b0;
                  req_done_q <= gnt_q;
                  req_err_q  <= 1'b1;
                  gap_cnt_q  <= '0;
                  state_q    <= ST_GAP;
               end else begin
                  en_q       <= 1'b1;
                  tmo_cnt_q  <= tmo_cnt_q + TW'(1);
               end
`else
               end else begin
                  en_q       <= 1'b1;
               end
`endif
            end
            ST_GAP: begin
               en_q <= 1'b0;
               if (gap_cnt_q == GW'(GAP - 1)) begin
                  if (|req_valid) begin
                     state_q <= ST_ARB;
                  end else begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  gap_cnt_q <= gap_cnt_q + GW'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               en_q    <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready      = req_ready_q;
   assign req_done       = req_done_q;
   assign busy           = busy_q;
   assign tx_mosi_data   = data_q;
   assign tx_mosi_enable = en_q;
`ifdef SPI_ARB_TIMEOUT_EN
   assign req_err        = req_err_q;
`else
   assign req_err        = 1'b0;
`endif

endmodule

// File: tb/tb_spi_host_arbiter.sv
// Directed self-checking bench for spi_host_arbiter: vector table for single frames,
// hand sequences for round-robin order, gap timing, mid-frame reset and watchdog.
module tb_spi_host_arbiter;

   localparam int NREQ = 4;
   localparam int AW   = 19;
   localparam int DW   = 16;
   localparam int SW   = 38;
   localparam int GAP  = 8;
   localparam int TMO  = 64;

   logic                host_clk = 1'b0;
   logic                host_rst_n = 1'b0;
   logic [NREQ-1:0]     req_valid = '0;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ-1:0]     req_wr = '0;
   logic [NREQ*AW-1:0]  req_addr = '0;
   logic [NREQ*DW-1:0]  req_wdata = '0;
   logic [NREQ-1:0]     req_done;
   logic                req_err;
   logic                busy;
   logic [SW-1:0]       tx_mosi_data;
   logic                tx_mosi_enable;
   logic                tx_mosi_done = 1'b0;

   spi_host_arbiter #(
      .NREQ(NREQ), .CW(2), .AW(AW), .DW(DW), .SW(SW), .GAP(GAP), .TIMEOUT(TMO)
   ) dut (
      .host_clk       (host_clk),
      .host_rst_n     (host_rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_wr         (req_wr),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .req_done       (req_done),
      .req_err        (req_err),
      .busy           (busy),
      .tx_mosi_data   (tx_mosi_data),
      .tx_mosi_enable (tx_mosi_enable),
      .tx_mosi_done   (tx_mosi_done)
   );

   always #5 host_clk = ~host_clk;

   typedef struct {
      int          id;
      logic        wr;
      logic [18:0] addr;
      logic [15:0] wdata;
      logic [37:0] exp_frame;
   } vec_t;

   vec_t vecs[5];
   int   n_tests = 0;
   int   n_fail  = 0;
   time  last_fall;
   bit   have_fall;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      host_rst_n   = 1'b0;
      req_valid    = '0;
      tx_mosi_done = 1'b0;
      have_fall    = 1'b0;
      repeat (2) @(negedge host_clk);
      host_rst_n   = 1'b1;
   endtask

   // Wait for grant of id, check it, complete the frame and check the done pulse.
   task automatic serve(input int id);
      int t;
      t = 0;
      while (req_ready == '0 && t < 60) begin
         @(negedge host_clk);
         t++;
      end
      chk($sformatf("grant_%0d", id), 64'(req_ready), 64'(1) << id);
      req_valid[id] = 1'b0;
      t = 0;
      while (!tx_mosi_enable && t < 10) begin
         @(negedge host_clk);
         t++;
      end
      chk("enable_up", 64'(tx_mosi_enable), 64'd1);
      if (have_fall) begin
         chk("gap_low_ge", 64'(($time - last_fall) / 10 >= GAP), 64'd1);
      end
      repeat (2) @(negedge host_clk);
      tx_mosi_done = 1'b1;
      @(negedge host_clk);
      tx_mosi_done = 1'b0;
      chk($sformatf("done_%0d", id), 64'(req_done), 64'(1) << id);
      chk("err_clear", 64'(req_err), 64'd0);
      chk("enable_drop", 64'(tx_mosi_enable), 64'd0);
      last_fall = $time;
      have_fall = 1'b1;
      @(negedge host_clk);
      chk("done_pulse", 64'(req_done), 64'd0);
   endtask

   initial begin
      int id;
      int hi;
      logic [3:0] seq_ids [5];

      vecs[0] = '{0, 1'b1, 19'h00000, 16'h1234, 38'h20_0000_1234};
      vecs[1] = '{1, 1'b0, 19'h00003, 16'hFFFF, 38'h10_0006_0000};
      vecs[2] = '{2, 1'b1, 19'h7FFFF, 16'hABCD, 38'h2F_FFFE_ABCD};
      vecs[3] = '{3, 1'b0, 19'h40001, 16'h5555, 38'h18_0002_0000};
      vecs[4] = '{0, 1'b1, 19'h12345, 16'h0001, 38'h22_468A_0001};

      // Reset values while reset is held
      repeat (3) @(negedge host_clk);
      chk("rst_busy",  64'(busy), 64'd0);
      chk("rst_en",    64'(tx_mosi_enable), 64'd0);
      chk("rst_data",  64'(tx_mosi_data), 64'd0);
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_done",  64'(req_done), 64'd0);
      chk("rst_err",   64'(req_err), 64'd0);
      host_rst_n = 1'b1;
      @(negedge host_clk);

      // Single-frame vectors with exact latency and gap timing
      for (int k = 0; k < 5; k++) begin
         id = vecs[k].id;
         req_wr[id]               = vecs[k].wr;
         req_addr[id*AW +: AW]    = vecs[k].addr;
         req_wdata[id*DW +: DW]   = vecs[k].wdata;
         req_valid[id]            = 1'b1;
         @(negedge host_clk);
         chk("arb_ready_low", 64'(req_ready), 64'd0);
         chk("arb_busy", 64'(busy), 64'd1);
         @(negedge host_clk);
         chk("ready", 64'(req_ready), 64'(1) << id);
         chk("en_in_arb", 64'(tx_mosi_enable), 64'd0);
         req_valid[id] = 1'b0;
         @(negedge host_clk);
         chk("en_send", 64'(tx_mosi_enable), 64'd1);
         chk("frame", 64'(tx_mosi_data), 64'(vecs[k].exp_frame));
         repeat (2) @(negedge host_clk);
         tx_mosi_done = 1'b1;
         @(negedge host_clk);
         tx_mosi_done = 1'b0;
         chk("vec_done", 64'(req_done), 64'(1) << id);
         chk("vec_en_drop", 64'(tx_mosi_enable), 64'd0);
         @(negedge host_clk);
         chk("vec_done_pulse", 64'(req_done), 64'd0);
         hi = 0;
         repeat (6) begin
            @(negedge host_clk);
            hi += int'(tx_mosi_enable);
         end
         chk("gap_en_low", 64'(hi), 64'd0);
         chk("gap_busy", 64'(busy), 64'd1);
         @(negedge host_clk);
         chk("gap_to_idle", 64'(busy), 64'd0);
         chk("data_hold", 64'(tx_mosi_data), 64'(vecs[k].exp_frame));
      end

      // Round-robin: all four valid from pointer 0, then {2,3}, then rotation check
      do_reset();
      req_valid = 4'b1111;
      seq_ids = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
      for (int k = 0; k < 4; k++) serve(int'(seq_ids[k]));
      req_valid = 4'b1100;
      serve(2);
      serve(3);
      have_fall = 1'b0;
      repeat (12) @(negedge host_clk);
      req_valid = 4'b0010;
      serve(1);
      have_fall = 1'b0;
      repeat (12) @(negedge host_clk);
      req_valid = 4'b1011;
      serve(3);
      serve(0);
      serve(1);

      // Done pulses in GAP and IDLE have no effect
      do_reset();
      req_valid = 4'b0011;
      serve(0);
      tx_mosi_done = 1'b1;
      @(negedge host_clk);
      tx_mosi_done = 1'b0;
      chk("done_in_gap", 64'(req_done), 64'd0);
      chk("en_in_gap", 64'(tx_mosi_enable), 64'd0);
      serve(1);
      repeat (12) @(negedge host_clk);
      tx_mosi_done = 1'b1;
      @(negedge host_clk);
      tx_mosi_done = 1'b0;
      chk("done_in_idle", 64'(req_done), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);

      // Reset mid-SEND after granting 2 (pointer 3); pointer must return to 0
      do_reset();
      req_valid = 4'b0100;
      repeat (4) @(negedge host_clk);
      req_valid = 4'b0000;
      chk("pre_rst_en", 64'(tx_mosi_enable), 64'd1);
      host_rst_n = 1'b0;
      @(negedge host_clk);
      chk("mid_rst_en", 64'(tx_mosi_enable), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_done", 64'(req_done), 64'd0);
      host_rst_n = 1'b1;
      @(negedge host_clk);
      req_valid = 4'b1111;
      serve(0);
      req_valid = 4'b0000;
      repeat (12) @(negedge host_clk);

`ifdef SPI_ARB_TIMEOUT_EN
      // Watchdog: done never returned
      do_reset();
      req_valid = 4'b0001;
      repeat (2) @(negedge host_clk);
      chk("tmo_ready", 64'(req_ready), 64'd1);
      req_valid = 4'b0000;
      repeat (63) @(negedge host_clk);
      chk("tmo_not_yet", 64'(req_done), 64'd0);
      chk("tmo_en_held", 64'(tx_mosi_enable), 64'd1);
      @(negedge host_clk);
      chk("tmo_done", 64'(req_done), 64'd1);
      chk("tmo_err", 64'(req_err), 64'd1);
      chk("tmo_en_drop", 64'(tx_mosi_enable), 64'd0);
      @(negedge host_clk);
      chk("tmo_err_pulse", 64'(req_err), 64'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
